// File: rtl/f_div_detect.sv
// f_div_detect -- divisor recovery for a clock-divider output.
//
// Measures the number of clk_in cycles between consecutive edges of sig_in,
// which is a divided clock generated from clk_in. It reports the equivalent
// divider setting, flags lock when the setting is stable, and flags a sticky
// timeout when no edge arrives.
//
// Ports:
//   clk_in   in   1      system clock, rising edge
//   reset    in   1      synchronous active-low reset, clears all state
//   sig_in   in   1      divided clock under measurement (synchronised here)
//   en       in   1      1 = measure; 0 = return to IDLE, clear err/locked
//   div_out  out  CNT_W  last measured divisor (edge spacing minus 1)
//   valid    out  1      one-cycle pulse when div_out is updated
//   locked   out  1      LOCK_N consecutive equal measurements seen
//   err      out  1      sticky timeout: no edge within 2^CNT_W cycles
module f_div_detect #(
    parameter int CNT_W  = 4,
    parameter int LOCK_N = 2
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             sig_in,
    input  logic             en,
    output logic [CNT_W-1:0] div_out,
    output logic             valid,
    output logic             locked,
    output logic             err
);

    localparam int LW = $clog2(LOCK_N + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [LW-1:0]    LOCK_MAX = LW'(LOCK_N);
    localparam logic [LW-1:0]    LOCK_ONE = LW'(1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_EDGE = 2'd1,
        MEASURE   = 2'd2,
        ERROR     = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             s1_q, s2_q, sprev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic             valid_q, valid_d;
    logic [LW-1:0]    lock_q, lock_d;
    logic             edge_w;

    // Either-polarity edge on the synchronised input.
    assign edge_w = s2_q ^ sprev_q;

    always_ff @(posedge clk_in) begin
        if (!reset) begin
            state_q <= IDLE;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            sprev_q <= 1'b0;
            cnt_q   <= '0;
            div_q   <= '0;
            valid_q <= 1'b0;
            lock_q  <= '0;
        end else begin
            state_q <= state_d;
            s1_q    <= sig_in;
            s2_q    <= s1_q;
            sprev_q <= s2_q;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            valid_q <= valid_d;
            lock_q  <= lock_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        valid_d = 1'b0;
        lock_d  = lock_q;
        if (!en) begin
            // Dropping enable discards any partial count without a valid.
            state_d = IDLE;
            cnt_d   = '0;
            lock_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d   = '0;
                    lock_d  = '0;
                    state_d = WAIT_EDGE;
                end
                WAIT_EDGE: begin
                    // First edge only establishes the phase reference.
                    if (edge_w) begin
                        cnt_d   = '0;
                        state_d = MEASURE;
                    end else if (cnt_q == CNT_MAX) begin
                        cnt_d   = '0;
                        state_d = ERROR;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                MEASURE: begin
                    if (edge_w) begin
                        div_d   = cnt_q;
                        valid_d = 1'b1;
                        cnt_d   = '0;
                        // lock_q is 0 only for the first measurement after
                        // alignment, which always restarts the run at 1.
                        if (lock_q != '0 && cnt_q == div_q)
                            lock_d = (lock_q == LOCK_MAX) ? LOCK_MAX : lock_q + LOCK_ONE;
                        else
                            lock_d = LOCK_ONE;
                    end else if (cnt_q == CNT_MAX) begin
                        cnt_d   = '0;
                        lock_d  = '0;
                        state_d = ERROR;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ERROR: begin
                    cnt_d  = '0;
                    lock_d = '0;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    lock_d  = '0;
                end
            endcase
        end
    end

    assign div_out = div_q;
    assign valid   = valid_q;
    assign locked  = (lock_q == LOCK_MAX);
    assign err     = (state_q == ERROR);

endmodule

// File: tb/tb_f_div_detect.sv
// Testbench for f_div_detect: divider-model stimulus, table-driven steady
// state readings plus directed multi-cycle corner sequences.
module tb_f_div_detect;

    logic       clk_in = 1'b0;
    logic       reset  = 1'b0;
    logic       sig    = 1'b0;
    logic       en     = 1'b0;
    logic [3:0] div_out;
    logic       valid;
    logic       locked;
    logic       err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Divider model: sig toggles every div_val+1 ticks while div_run is set.
    int div_val = 0;
    int dcnt    = 0;
    bit div_run = 1'b0;

    f_div_detect #(.CNT_W(4), .LOCK_N(2)) dut (
        .clk_in  (clk_in),
        .reset   (reset),
        .sig_in  (sig),
        .en      (en),
        .div_out (div_out),
        .valid   (valid),
        .locked  (locked),
        .err     (err)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int d;          // divider setting applied
        int skip;       // transition readings to ignore
        int nval;       // readings to check
        int exp_div;    // expected div_out
        int lock_first; // expected locked on first checked reading
    } row_t;

    row_t rows[5];

    task automatic tick();
        @(posedge clk_in);
        #1;
        cyc++;
        if (div_run) begin
            if (dcnt >= div_val) begin
                sig  = ~sig;
                dcnt = 0;
            end else begin
                dcnt++;
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (valid === 1'b1) begin
                ok = 1'b1;
                return;
            end
        end
        chk("valid_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        int last;
        int rec;

        rows[0] = '{d: 5,  skip: 0, nval: 4, exp_div: 5,  lock_first: 0};
        rows[1] = '{d: 9,  skip: 0, nval: 3, exp_div: 9,  lock_first: 0};
        rows[2] = '{d: 15, skip: 0, nval: 3, exp_div: 15, lock_first: 0};
        rows[3] = '{d: 3,  skip: 0, nval: 3, exp_div: 3,  lock_first: 0};
        rows[4] = '{d: 0,  skip: 1, nval: 4, exp_div: 0,  lock_first: 0};

        // Reset state
        for (int i = 0; i < 3; i++) tick();
        chk("rst_div", div_out, 0);
        chk("rst_valid", valid, 0);
        chk("rst_locked", locked, 0);
        chk("rst_err", err, 0);
        reset = 1'b1;
        tick();

        // Steady-state readings, including divider changes mid-run
        en = 1'b1; div_run = 1'b1; dcnt = 0; last = -1;
        foreach (rows[r]) begin
            div_val = rows[r].d;
            for (int k = 0; k < rows[r].skip + rows[r].nval; k++) begin
                wait_valid(ok);
                if (!ok) break;
                if (k >= rows[r].skip) begin
                    chk($sformatf("row%0d_div", r), div_out, rows[r].exp_div);
                    chk($sformatf("row%0d_locked", r), locked,
                        (k == rows[r].skip) ? rows[r].lock_first : 1);
                    chk($sformatf("row%0d_err", r), err, 0);
                    if (last >= 0)
                        chk($sformatf("row%0d_spacing", r), cyc - last, rows[r].d + 1);
                end
                last = cyc;
            end
        end

        // Timeout: sig frozen, err after 16 edge-free cycles in WAIT_EDGE
        en = 1'b0; div_run = 1'b0;
        tick();
        chk("idle_valid", valid, 0);
        chk("idle_locked", locked, 0);
        chk("idle_err", err, 0);
        for (int i = 0; i < 3; i++) tick();
        en = 1'b1;
        for (int i = 0; i < 16; i++) tick();
        chk("to_err_early", err, 0);
        tick();
        chk("to_err_set", err, 1);
        chk("to_locked", locked, 0);
        for (int i = 0; i < 3; i++) tick();
        chk("to_err_sticky", err, 1);
        chk("to_valid", valid, 0);
        en = 1'b0;
        tick();
        chk("to_err_clear", err, 0);
        en = 1'b1; div_val = 2; dcnt = 0; div_run = 1'b1;
        wait_valid(ok);
        chk("resume1_div", div_out, 2);
        chk("resume1_locked", locked, 0);
        wait_valid(ok);
        chk("resume2_div", div_out, 2);
        chk("resume2_locked", locked, 1);

        // Valid is a single-cycle pulse; reset mid-MEASURE clears everything
        tick();
        chk("valid_pulse", valid, 0);
        reset = 1'b0;
        tick();
        chk("mrst_div", div_out, 0);
        chk("mrst_valid", valid, 0);
        chk("mrst_locked", locked, 0);
        chk("mrst_err", err, 0);
        reset = 1'b1;
        tick();
        chk("mrst_valid_p1", valid, 0);
        tick();
        chk("mrst_valid_p2", valid, 0);
        for (int i = 0; i < 3; i++) wait_valid(ok);
        chk("mrst_relock_div", div_out, 2);
        chk("mrst_relock_locked", locked, 1);

        // en dropped in the cycle the edge is seen: no valid, realign
        wait_valid(ok);
        tick();
        tick();
        en = 1'b0;
        tick();
        chk("en0_valid", valid, 0);
        chk("en0_locked", locked, 0);
        en = 1'b1;
        rec = cyc;
        wait_valid(ok);
        chk("realign_latency", cyc - rec, 6);
        chk("realign_div", div_out, 2);
        chk("realign_locked", locked, 0);
        wait_valid(ok);
        chk("realign2_locked", locked, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
